// File: rtl/score_digit_scanner.sv
// rtl/score_digit_scanner.sv - four-digit BCD score counter with scan select for the display mux
// Score saturates at 9999; a sticky flag marks reaching TARGET_BCD.
module score_digit_scanner #(
  parameter int          REFRESH_DIV = 100000,
  parameter logic [15:0] TARGET_BCD  = 16'h0010
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SCORE_INC,
  input  logic       SCORE_CLR,
  output logic [4:0] DIGIT0,
  output logic [4:0] DIGIT1,
  output logic [4:0] DIGIT2,
  output logic [4:0] DIGIT3,
  output logic [1:0] STROBE_SEL,
  output logic       TARGET_REACHED
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  logic [15:0]   score_q, score_d;
  logic          flag_q, flag_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    strobe_q, strobe_d;
  logic          carry;

  always_comb begin
    score_d = score_q;
    flag_d  = flag_q;
    carry   = 1'b0;
    if (SCORE_CLR) begin
      score_d = 16'h0000;
    end else if (SCORE_INC && score_q != 16'h9999) begin
      // Ripple the carry through all four digits in a single cycle.
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (score_q[4*i +: 4] == 4'd9) begin
            score_d[4*i +: 4] = 4'd0;
          end else begin
            score_d[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    // Packed BCD orders the same as its decimal value, so a plain compare works.
    if (SCORE_CLR) begin
      flag_d = 1'b0;
    end else begin
      flag_d = flag_q | (score_d >= TARGET_BCD);
    end
  end

  always_comb begin
    presc_d  = presc_q + PW'(1);
    strobe_d = strobe_q;
    if (presc_q == PRESC_LAST) begin
      presc_d  = '0;
      strobe_d = strobe_q + 2'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      score_q  <= 16'h0000;
      flag_q   <= 1'b0;
      presc_q  <= '0;
      strobe_q <= 2'b00;
    end else begin
      score_q  <= score_d;
      flag_q   <= flag_d;
      presc_q  <= presc_d;
      strobe_q <= strobe_d;
    end
  end

  assign DIGIT0         = {flag_q, score_q[3:0]};
  assign DIGIT1         = {1'b0, score_q[7:4]};
  assign DIGIT2         = {1'b0, score_q[11:8]};
  assign DIGIT3         = {1'b0, score_q[15:12]};
  assign STROBE_SEL     = strobe_q;
  assign TARGET_REACHED = flag_q;

endmodule

// File: tb/tb_score_digit_scanner.sv
// tb/tb_score_digit_scanner.sv - scoreboard bench for score_digit_scanner
// The model keeps the score as a decimal integer and derives the scan slot from cycles since reset.
module tb_score_digit_scanner;

  localparam int          DIV = 4;
  localparam logic [15:0] TGT = 16'h0010;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       SCORE_INC = 1'b0;
  logic       SCORE_CLR = 1'b0;
  logic [4:0] DIGIT0, DIGIT1, DIGIT2, DIGIT3;
  logic [1:0] STROBE_SEL;
  logic       TARGET_REACHED;

  score_digit_scanner #(.REFRESH_DIV(DIV), .TARGET_BCD(TGT)) dut (
    .CLK(CLK), .RESET(RESET), .SCORE_INC(SCORE_INC), .SCORE_CLR(SCORE_CLR),
    .DIGIT0(DIGIT0), .DIGIT1(DIGIT1), .DIGIT2(DIGIT2), .DIGIT3(DIGIT3),
    .STROBE_SEL(STROBE_SEL), .TARGET_REACHED(TARGET_REACHED)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0] d0, d1, d2, d3;
    logic [1:0] sel;
    logic       flag;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  int   m_score = 0;
  bit   m_flag  = 1'b0;
  int   m_k     = 0;
  int   tgt_dec;
  string phase = "init";

  function automatic exp_t make_exp();
    exp_t e;
    e.d0   = {m_flag, 4'(m_score % 10)};
    e.d1   = {1'b0, 4'((m_score / 10) % 10)};
    e.d2   = {1'b0, 4'((m_score / 100) % 10)};
    e.d3   = {1'b0, 4'((m_score / 1000) % 10)};
    e.sel  = 2'((m_k / DIV) % 4);
    e.flag = m_flag;
    e.tag  = phase;
    return e;
  endfunction

  task automatic cyc(input bit rst, input bit inc, input bit clr);
    @(negedge CLK);
    RESET = rst;
    SCORE_INC = inc;
    SCORE_CLR = clr;
    if (rst) begin
      m_score = 0;
      m_flag  = 1'b0;
      m_k     = 0;
    end else begin
      if (clr) m_score = 0;
      else if (inc && m_score < 9999) m_score++;
      m_flag = clr ? 1'b0 : (m_flag | (m_score >= tgt_dec));
      m_k++;
    end
    exp_q.push_back(make_exp());
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
    end
  endtask

  // Monitor: the design presents a fresh output word every cycle.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n_cmp++;
        if ({DIGIT3, DIGIT2, DIGIT1, DIGIT0, STROBE_SEL, TARGET_REACHED} !==
            {e.d3, e.d2, e.d1, e.d0, e.sel, e.flag}) begin
          n_err++;
          $display("FAIL %s: got D3..D0=%h %h %h %h sel=%0d flag=%b, expected %h %h %h %h sel=%0d flag=%b",
                   e.tag, DIGIT3, DIGIT2, DIGIT1, DIGIT0, STROBE_SEL, TARGET_REACHED,
                   e.d3, e.d2, e.d1, e.d0, e.sel, e.flag);
        end
      end
    end
  end

  initial begin
    tgt_dec = 1000 * int'(TGT[15:12]) + 100 * int'(TGT[11:8]) + 10 * int'(TGT[7:4]) + int'(TGT[3:0]);

    phase = "reset";
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);

    phase = "scan";
    for (int c = 1; c <= 20; c++) cyc(1'b0, 1'b0, c == 6);

    phase = "carry";
    pulses(99);
    pulses(1);

    phase = "target";
    cyc(1'b0, 1'b0, 1'b1);
    pulses(10);
    pulses(5);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0);
    end

    phase = "midreset";
    cyc(1'b0, 1'b0, 1'b1);
    pulses(42);
    for (int i = 0; i < 4 * DIV && ((m_k / DIV) % 4) != 2; i++) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3 * DIV; i++) cyc(1'b0, 1'b0, 1'b0);

    phase = "saturate";
    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10005; i++) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    phase = "tail";
    @(negedge CLK);
    SCORE_INC = 1'b0;
    SCORE_CLR = 1'b0;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/score_digit_scanner.md
Name: score_digit_scanner

Overview:
- Upstream feeder for the 4-way 5-bit digit multiplexer on the seven-segment display path.
- Holds the game score as four BCD digits and increments it on score events from game control.
- Presents the digits as four 5-bit words {flag, BCD} on DIGIT0..DIGIT3. These connect to IN0..IN3 of the mux.
- Generates the 2-bit scan select STROBE_SEL. This connects to the mux CONTROL input.

Parameters:
- REFRESH_DIV, 100000: CLK cycles per digit slot. 100 MHz gives 1 kHz per digit and 250 Hz full-frame refresh. Legal range is >=2.
- TARGET_BCD, 16'h0010: win threshold as four packed BCD digits {D3,D2,D1,D0}.

Ports:
- CLK  input  1  system clock; all logic is on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- SCORE_INC  input  1  each cycle sampled high adds one to the score.
- SCORE_CLR  input  1  synchronous clear of the score and the target flag.
- DIGIT0  output  5  {TARGET_REACHED, D0}; D0 is the units BCD digit.
- DIGIT1  output  5  {1'b0, D1}; D1 is the tens digit.
- DIGIT2  output  5  {1'b0, D2}; D2 is the hundreds digit.
- DIGIT3  output  5  {1'b0, D3}; D3 is the thousands digit.
- STROBE_SEL  output  2  active digit select for the display mux and anode decode.
- TARGET_REACHED  output  1  sticky flag: score has reached TARGET_BCD.

Behaviour:
- One clock, CLK. RESET is synchronous and active-high. All outputs are registered.
- Reset values:
  - DIGIT0..DIGIT3 = 5'b00000.
  - STROBE_SEL = 2'b00.
  - TARGET_REACHED = 0.
  - Prescaler = 0.
- Score priority each cycle: RESET > SCORE_CLR > SCORE_INC > hold.
- Increment:
  - D0 += 1. At 9 it wraps to 0 and carries into D1; the carry ripples the same way through D2 and D3, all in one cycle.
  - Result is visible on DIGITn the cycle after SCORE_INC is sampled high (latency 1).
  - SCORE_INC held high for N cycles gives N increments.
- Saturation: at 9999, further SCORE_INC is ignored. Digits hold 9999; no wrap to 0000.
- BCD invariant: no digit ever takes a value of 10-15.
- SCORE_CLR clears D3..D0 and TARGET_REACHED next cycle. It does not disturb the prescaler or STROBE_SEL.
- TARGET_REACHED:
  - Set in the same cycle the registered score becomes >= TARGET_BCD. The compare is on the next-score value, so flag and digits update together.
  - Sticky until RESET or SCORE_CLR.
  - The compare is BCD-packed magnitude (equivalent to unsigned compare of the 16-bit packed value).
  - If TARGET_BCD = 16'h0000, the flag sets on the first cycle after reset or clear.
- Scan prescaler:
  - Counter width $clog2(REFRESH_DIV). It counts 0..REFRESH_DIV-1 every cycle, independent of score activity.
  - On terminal count it returns to 0 and STROBE_SEL increments modulo 4: 00->01->10->11->00.
  - STROBE_SEL first changes REFRESH_DIV cycles after RESET deasserts.
- RESET mid-operation: score, flag, prescaler and STROBE_SEL all return to reset values next cycle, regardless of SCORE_INC or SCORE_CLR.
- DIGIT1..3 bit 4 is tied to 0. DIGIT0 bit 4 mirrors TARGET_REACHED and drives the units decimal point.

Test Plan:
- Reset: REFRESH_DIV=4, assert RESET for 2 cycles with SCORE_INC=1 -> all DIGITn=0, STROBE_SEL=00, TARGET_REACHED=0 throughout.
- Scan: REFRESH_DIV=4, release RESET at cycle 0 -> STROBE_SEL = 01, 10, 11, 00 at cycles 4, 8, 12, 16, repeating every 16 cycles. Also check it is unaffected by a SCORE_CLR at cycle 6.
- Carry ripple: 99 single-cycle SCORE_INC pulses -> digits 0,0,9,9. One more pulse -> DIGIT0=0, DIGIT1=0, DIGIT2=1, DIGIT3=0 one cycle after the pulse.
- Saturation: hold SCORE_INC for 10005 cycles -> digits 9,9,9,9 from the 9999th increment onward; never 0000.
- Target: TARGET_BCD=16'h0010, 10 pulses -> TARGET_REACHED=1 and DIGIT0=5'b10000 in the same cycle DIGIT1 becomes 1. Flag stays 1 after 5 more pulses. SCORE_CLR together with SCORE_INC -> score 0000, flag 0 next cycle.
- Mid-run reset: score 0042 with STROBE_SEL=10, pulse RESET for one cycle -> next cycle all zero. Scan then restarts with the first STROBE_SEL change REFRESH_DIV cycles later.
